// File: rtl/xor_share_pkg.sv
// Shared types and constants for the round-robin Xor sharing arbiter.
package xor_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          OP_COUNT_W   = 16;
    localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/Xor.sv
// Single-bit Xor datapath cell shared by all requesters.
module Xor (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = a ^ b;

endmodule

// File: rtl/xor_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module xor_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [31:0] idx;

    // Walk the search order backwards so the last hit is the highest priority.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (32'(ptr) + 32'(k)) % 32'(N_REQ);
            if (req[idx[ID_W-1:0]]) begin
                gnt_id = idx[ID_W-1:0];
                any    = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter granting N_REQ requesters shared access to WIDTH Xor cells.
module xor_share_arbiter
    import xor_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_c,
    input  logic                   rsp_ready,
    output logic                   busy,
    output logic [OP_COUNT_W-1:0]  op_count
);

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] xor_c;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             any;
    logic             accept;

    xor_rr_pick #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .any   (any)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_xor
        Xor u_xor (
            .a(opa[i]),
            .b(opb[i]),
            .c(xor_c[i])
        );
    end

    // The picker only grants a valid requester, so a grant in IDLE is an acceptance.
    assign req_ready = (state == IDLE) ? gnt : '0;
    assign accept    = (state == IDLE) && any;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            opa       <= '0;
            opb       <= '0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= (state_next == RESP);
            busy      <= (state_next != IDLE);
            if (accept) begin
                opa    <= req_a[gnt_id*WIDTH +: WIDTH];
                opb    <= req_b[gnt_id*WIDTH +: WIDTH];
                rsp_id <= gnt_id;
                ptr    <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                rsp_c <= xor_c;
            end
            if ((state == RESP) && rsp_ready && (op_count != OP_COUNT_MAX)) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
